// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter through a start/busy handshake.
// A queued byte is popped into tx_data, launched with a one-cycle tx_start,
// then the feeder waits for the transmitter to raise and drop tx_busy.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a queued byte and an idle transmitter
// LAUNCH    | tx_start asserted for this single cycle
// WAIT_BUSY | waiting (bounded by BUSY_TIMEOUT) for tx_busy to rise
// WAIT_DONE | transmitter busy; waiting for tx_busy to fall
module uart_tx_feeder #(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  tx_error,
  input  logic                  flags_clr,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  output logic [15:0]           sent_count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} feederState;

  feederState            state, stateNext;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0]      countNext;
  logic [TMR_W-1:0]      busyTimer;
  logic                  push, pop, loadTimer, timeoutHit, doneHit;

  // Full is the registered pre-edge value, so a write racing a pop is dropped.
  assign push = wr_en && !fifo_full;

  // Occupancy for the next cycle; a simultaneous push and pop cancel out.
  always_comb begin
    countNext = fifo_count;
    case ({push, pop})
      2'b10:   countNext = fifo_count + CNT_W'(1);
      2'b01:   countNext = fifo_count - CNT_W'(1);
      default: countNext = fifo_count;
    endcase
  end

  // Byte storage; not cleared by reset, stale entries are never read.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wrPtr] <= wr_data;
  end

  // FIFO pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (push) wrPtr <= wrPtr + DEPTH_LOG2'(1);
      if (pop)  rdPtr <= rdPtr + DEPTH_LOG2'(1);
      fifo_count <= countNext;
      fifo_full  <= (countNext == CNT_W'(DEPTH));
      fifo_empty <= (countNext == '0);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state decode and handshake strobes.
  always_comb begin
    stateNext  = state;
    pop        = 1'b0;
    tx_start   = 1'b0;
    loadTimer  = 1'b0;
    timeoutHit = 1'b0;
    doneHit    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop       = 1'b1;
          stateNext = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start  = 1'b1;
        loadTimer = 1'b1;
        stateNext = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          stateNext = WAIT_DONE;
        end else if (busyTimer == TMR_W'(1)) begin
          timeoutHit = 1'b1;
          stateNext  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          doneHit   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Down-counter bounding the wait for tx_busy; expires on its last cycle at 1.
  always_ff @(posedge clk) begin
    if (rst)                                   busyTimer <= '0;
    else if (loadTimer)                        busyTimer <= TMR_W'(BUSY_TIMEOUT);
    else if (state == WAIT_BUSY && busyTimer != '0) busyTimer <= busyTimer - TMR_W'(1);
  end

  // Launch register: held from the pop until the next pop so the transmitter can use it unregistered.
  always_ff @(posedge clk) begin
    if (rst)      tx_data <= 8'h00;
    else if (pop) tx_data <= mem[rdPtr];
  end

  // Sticky flags (a set in the same cycle beats a clear) and the completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      tx_error   <= 1'b0;
      sent_count <= 16'h0000;
    end else begin
      overflow <= (wr_en && fifo_full) || (overflow && !flags_clr);
      tx_error <= timeoutHit || (tx_error && !flags_clr);
      if (doneHit) sent_count <= sent_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios plus a random phase, all checked
// against a queue-based reference model and a behavioural transmitter.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, wr_en, flags_clr, tx_busy;
  logic [7:0]  wr_data;
  logic        fifo_full, fifo_empty, overflow, tx_error, tx_start;
  logic [4:0]  fifo_count;
  logic [7:0]  tx_data;
  logic [15:0] sent_count;

  uart_tx_feeder #(.DEPTH_LOG2(4), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .overflow(overflow), .tx_error(tx_error), .flags_clr(flags_clr),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int          nAssert = 0, nFail = 0;
  logic [7:0]  q[$];
  logic [7:0]  curByte = 8'h00;
  logic [15:0] modelSent = 16'h0000;
  bit          modelOvf = 0, modelErr = 0, outstanding = 0;
  bit          pendingRise = 0, fallPending = 0, lastLaunch = 0;
  int          xmitMode = 0;   // 0 responsive transmitter, 1 silent, 2 held busy
  int          busyLen = 3, busyLeft = 0, toCount = 0;
  int          launches = 0, accepted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict from the queue model, advance, compare, drive the transmitter.
  task automatic tick();
    int szBefore;
    bit acc, ovfSet, errSet, doneSet, busyAtEdge, rstAtEdge;
    szBefore   = q.size();
    acc        = wr_en && (szBefore < DEPTH);
    ovfSet     = wr_en && (szBefore == DEPTH);
    errSet     = 0;
    doneSet    = 0;
    if (toCount > 0) begin
      toCount--;
      if (toCount == 0) errSet = 1;
    end
    if (fallPending) begin
      doneSet = 1;
      fallPending = 0;
    end
    busyAtEdge = tx_busy;
    rstAtEdge  = rst;
    @(posedge clk);
    #1;
    lastLaunch = 0;
    if (rstAtEdge) begin
      q.delete();
      modelSent = 0; modelOvf = 0; modelErr = 0; outstanding = 0;
      pendingRise = 0; fallPending = 0; toCount = 0; tx_busy = 0;
      chk("reset_outputs", 32'({tx_start, tx_data, fifo_count, fifo_empty, fifo_full, overflow, tx_error}),
          32'({1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
      chk("reset_sent", 32'(sent_count), 32'd0);
    end else begin
      if (acc) begin
        q.push_back(wr_data);
        accepted++;
      end
      modelOvf = ovfSet || (modelOvf && !flags_clr);
      modelErr = errSet || (modelErr && !flags_clr);
      if (errSet || doneSet) outstanding = 0;
      if (doneSet) modelSent++;
      if (tx_start) begin
        lastLaunch = 1;
        launches++;
        chk("launch_legal", 32'({outstanding, szBefore > 0, busyAtEdge}), 32'(3'b010));
        if (q.size() > 0) curByte = q.pop_front();
        outstanding = 1;
        if (xmitMode == 1) toCount = 5;
        else if (xmitMode == 0) pendingRise = 1;
      end
      if (outstanding) chk("tx_data_hold", 32'(tx_data), 32'(curByte));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("flags", 32'({fifo_full, fifo_empty, overflow, tx_error}),
          32'({q.size() == DEPTH, q.size() == 0, modelOvf, modelErr}));
      chk("sent_count", 32'(sent_count), 32'(modelSent));
      if (xmitMode == 2) begin
        tx_busy = 1;
      end else if (!lastLaunch && pendingRise) begin
        tx_busy = 1;
        busyLeft = busyLen;
        pendingRise = 0;
      end else if (tx_busy && xmitMode == 0) begin
        busyLeft--;
        if (busyLeft <= 0) begin
          tx_busy = 0;
          fallPending = 1;
        end
      end
    end
  endtask

  task automatic waitIdle(input int maxC);
    int n;
    n = 0;
    while ((outstanding || q.size() > 0) && n < maxC) begin
      tick();
      n++;
    end
    chk("drain_within_budget", 32'(n < maxC), 32'd1);
  endtask

  initial begin
    int l0, a0, t, first, second;
    logic [15:0] sentBase;
    rst = 1; wr_en = 0; wr_data = 8'h00; flags_clr = 0; tx_busy = 0;
    tick();
    tick();
    rst = 0;

    // Single byte with a long busy pulse, plus write-to-launch latency.
    busyLen = 100;
    l0 = launches;
    wr_en = 1; wr_data = 8'h55;
    tick();
    wr_en = 0;
    chk("latency_not_yet", 32'(tx_start), 32'd0);
    tick();
    chk("latency_launch", 32'(tx_start), 32'd1);
    chk("single_data", 32'(tx_data), 32'h55);
    waitIdle(200);
    chk("single_launches", 32'(launches - l0), 32'd1);
    chk("single_sent", 32'(sent_count), 32'd1);
    chk("single_empty", 32'(fifo_empty), 32'd1);

    // Burst of 16 while transmitter is held busy, then drained in order.
    l0 = launches; sentBase = modelSent;
    xmitMode = 2; tx_busy = 1;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1; wr_data = 8'(i);
      tick();
    end
    wr_en = 0;
    chk("burst_full", 32'(fifo_full), 32'd1);
    xmitMode = 0; tx_busy = 0; busyLen = 2;
    waitIdle(500);
    chk("burst_launches", 32'(launches - l0), 32'd16);
    chk("burst_sent", 32'(sent_count), 32'(sentBase + 16'd16));

    // Overflow: 17 writes while busy, then clear.
    xmitMode = 2; tx_busy = 1;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1; wr_data = 8'hA0 + 8'(i);
      tick();
    end
    wr_en = 0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(fifo_count), 32'd16);
    flags_clr = 1;
    tick();
    flags_clr = 0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Write racing an IDLE pop on a full FIFO is dropped.
    xmitMode = 0; tx_busy = 0;
    wr_en = 1; wr_data = 8'hEE;
    tick();
    wr_en = 0;
    chk("simul_launch", 32'(tx_start), 32'd1);
    chk("simul_count", 32'(fifo_count), 32'd15);
    chk("simul_ovf", 32'(overflow), 32'd1);
    waitIdle(1000);
    flags_clr = 1;
    tick();
    flags_clr = 0;

    // Busy never rises: timeout, error flag, next byte launched.
    xmitMode = 1; sentBase = modelSent;
    t = 0; first = -1; second = -1;
    while (second < 0 && t < 60) begin
      wr_en = (t < 2);
      wr_data = (t == 0) ? 8'h11 : 8'h22;
      tick();
      if (lastLaunch) begin
        if (first < 0) first = t;
        else second = t;
      end
      t++;
    end
    wr_en = 0;
    chk("timeout_relaunch_gap", 32'(second - first), 32'd6);
    chk("timeout_err", 32'(tx_error), 32'd1);
    chk("timeout_sent", 32'(sent_count), 32'(sentBase));
    waitIdle(50);
    flags_clr = 1;
    tick();
    flags_clr = 0;
    chk("err_clear", 32'(tx_error), 32'd0);
    xmitMode = 0;

    // Reset in WAIT_DONE with 5 bytes queued.
    busyLen = 50;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1; wr_data = 8'hC0 + 8'(i);
      tick();
    end
    wr_en = 0;
    tick();
    tick();
    chk("pre_rst_count", 32'(fifo_count), 32'd5);
    chk("pre_rst_busy", 32'(tx_busy), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    l0 = launches;
    for (int i = 0; i < 20; i++) tick();
    chk("no_launch_after_rst", 32'(launches - l0), 32'd0);
    busyLen = 2;
    wr_en = 1; wr_data = 8'h3C;
    tick();
    wr_en = 0;
    waitIdle(50);
    chk("post_rst_launch", 32'(launches - l0), 32'd1);
    chk("post_rst_sent", 32'(sent_count), 32'd1);

    // Random traffic against the model.
    l0 = launches; a0 = accepted;
    for (int i = 0; i < 400; i++) begin
      wr_en     = ($urandom_range(0, 99) < 45);
      wr_data   = 8'($urandom);
      flags_clr = ($urandom_range(0, 19) == 0);
      busyLen   = $urandom_range(1, 6);
      tick();
    end
    wr_en = 0; flags_clr = 0;
    waitIdle(2000);
    chk("rand_all_launched", 32'(launches - l0), 32'(accepted - a0));

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
